// File: rtl/vga_rx_pkg.sv
`default_nettype none
//==============================================================================
// Module : vga_rx_pkg
// Shared register map, STATUS bit indices, FSM states and CRC constants
// for vga_rx_monitor.
// Rev    : 1.0  initial release
//==============================================================================
package vga_rx_pkg;

    localparam logic [2:0] C_ADDR_STATUS      = 3'd0;
    localparam logic [2:0] C_ADDR_LINE_PIXELS = 3'd1;
    localparam logic [2:0] C_ADDR_FRAME_LINES = 3'd2;
    localparam logic [2:0] C_ADDR_HS_PERIOD   = 3'd3;
    localparam logic [2:0] C_ADDR_FRAME_COUNT = 3'd4;
    localparam logic [2:0] C_ADDR_CRC         = 3'd5;

    localparam int C_STAT_LOCKED   = 0;
    localparam int C_STAT_ERROR    = 1;
    localparam int C_STAT_DONE     = 2;
    localparam int C_STAT_IN_FRAME = 3;

    typedef enum logic [0:0] {
        ST_WAIT_VS  = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    localparam logic [15:0] C_CRC_POLY = 16'h1021;
    localparam logic [15:0] C_CRC_SEED = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_rx_crc16.sv
`default_nettype none
//==============================================================================
// Module : vga_rx_crc16
// One pixel (r,g,b bytes, MSB first) of CRC-16-CCITT per call, combinational.
// Rev    : 1.0  initial release
//==============================================================================
module vga_rx_crc16
    import vga_rx_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [23:0] i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int i = 23; i >= 0; i--) begin
            w_c = {w_c[14:0], 1'b0} ^ ((w_c[15] ^ i_data[i]) ? C_CRC_POLY : 16'h0000);
        end
        o_crc = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/vga_rx_monitor.sv
`default_nettype none
//==============================================================================
// Module : vga_rx_monitor
// Measures incoming VGA raster timing and exposes it over Avalon-MM.
// Optional frame CRC enabled by defining VGA_RX_CRC_EN.
// Rev    : 1.0  initial release
//==============================================================================
module vga_rx_monitor
    import vga_rx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        frame_irq
);

    logic        r_hs, r_vs, r_blank, r_hs_d, r_vs_d;
    logic [7:0]  r_r, r_g, r_b;
    state_t      r_state, w_state_next;
    logic        w_latch;
    logic [15:0] r_pix_cnt, r_last_width, r_line_cnt, r_hs_clk, r_hs_period;
    logic [15:0] r_line_pixels, r_frame_lines, r_hs_period_lat;
    logic [31:0] r_frame_count, r_rdata, w_rd_data, w_status;
    logic        r_locked, r_error, r_done, r_irq;
    logic [15:0] w_pix_next, w_width_cur, w_lines_cur, w_period_cur, w_crc_rd;
    logic        w_hs_fall, w_vs_fall, w_line_close, w_match, w_clr_wr;
    logic        w_unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_hs, r_vs, r_blank, r_hs_d, r_vs_d} <= '0;
            {r_r, r_g, r_b}                        <= '0;
        end else begin
            r_hs    <= vga_hs;
            r_vs    <= vga_vs;
            r_blank <= vga_blank;
            r_hs_d  <= r_hs;
            r_vs_d  <= r_vs;
            r_r     <= vga_r;
            r_g     <= vga_g;
            r_b     <= vga_b;
        end
    end

    assign w_hs_fall = r_hs_d & ~r_hs;
    assign w_vs_fall = r_vs_d & ~r_vs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_WAIT_VS;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ST_WAIT_VS:  if (w_vs_fall) w_state_next = ST_IN_FRAME;
            ST_IN_FRAME: w_latch = w_vs_fall;
        endcase
    end

    // "_cur" values fold in a line closing this cycle, so a coincident hs/vs
    // fall closes the line before the frame is latched.
    assign w_pix_next   = r_blank ? sat_inc16(r_pix_cnt) : r_pix_cnt;
    assign w_line_close = w_hs_fall && (w_pix_next != 16'd0);
    assign w_width_cur  = w_line_close ? w_pix_next : r_last_width;
    assign w_lines_cur  = w_line_close ? sat_inc16(r_line_cnt) : r_line_cnt;
    assign w_period_cur = w_hs_fall ? sat_inc16(r_hs_clk) : r_hs_period;
    assign w_match      = (w_width_cur == 16'(H_ACTIVE)) && (w_lines_cur == 16'(V_ACTIVE));
    assign w_clr_wr     = avs_write && (avs_address == C_ADDR_STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt       <= '0;
            r_last_width    <= '0;
            r_line_cnt      <= '0;
            r_hs_clk        <= '0;
            r_hs_period     <= '0;
            r_line_pixels   <= '0;
            r_frame_lines   <= '0;
            r_hs_period_lat <= '0;
            r_frame_count   <= '0;
            r_locked        <= 1'b0;
            r_error         <= 1'b0;
            r_done          <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_pix_cnt   <= w_hs_fall ? 16'd0 : w_pix_next;
            r_hs_clk    <= w_hs_fall ? 16'd0 : sat_inc16(r_hs_clk);
            r_hs_period <= w_period_cur;
            if (w_vs_fall) begin
                r_last_width <= '0;
                r_line_cnt   <= '0;
            end else begin
                r_last_width <= w_width_cur;
                r_line_cnt   <= w_lines_cur;
            end
            r_irq <= w_latch;
            if (w_latch) begin
                r_line_pixels   <= w_width_cur;
                r_frame_lines   <= w_lines_cur;
                r_hs_period_lat <= w_period_cur;
                r_frame_count   <= r_frame_count + 32'd1;
                r_locked        <= w_match;
            end
            // A set in the same cycle as a software clear takes priority.
            if (w_latch && !w_match)                    r_error <= 1'b1;
            else if (w_clr_wr && avs_writedata[1])      r_error <= 1'b0;
            if (w_latch)                                r_done  <= 1'b1;
            else if (w_clr_wr && avs_writedata[2])      r_done  <= 1'b0;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] r_crc, r_crc_lat, w_crc_step, w_crc_cur;

    vga_rx_crc16 u_crc16 (
        .i_crc  (r_crc),
        .i_data ({r_r, r_g, r_b}),
        .o_crc  (w_crc_step)
    );

    assign w_crc_cur = r_blank ? w_crc_step : r_crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc     <= C_CRC_SEED;
            r_crc_lat <= '0;
        end else begin
            r_crc <= w_vs_fall ? C_CRC_SEED : w_crc_cur;
            if (w_latch) r_crc_lat <= w_crc_cur;
        end
    end

    assign w_crc_rd = r_crc_lat;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = ^{r_r, r_g, r_b};
    assign w_crc_rd     = '0;
`endif

    assign w_unused_wdata = ^{avs_writedata[31:3], avs_writedata[0]};

    always_comb begin
        w_status                  = '0;
        w_status[C_STAT_LOCKED]   = r_locked;
        w_status[C_STAT_ERROR]    = r_error;
        w_status[C_STAT_DONE]     = r_done;
        w_status[C_STAT_IN_FRAME] = (r_state == ST_IN_FRAME);
        w_rd_data = '0;
        case (avs_address)
            C_ADDR_STATUS:      w_rd_data = w_status;
            C_ADDR_LINE_PIXELS: w_rd_data = {16'd0, r_line_pixels};
            C_ADDR_FRAME_LINES: w_rd_data = {16'd0, r_frame_lines};
            C_ADDR_HS_PERIOD:   w_rd_data = {16'd0, r_hs_period_lat};
            C_ADDR_FRAME_COUNT: w_rd_data = r_frame_count;
            C_ADDR_CRC:         w_rd_data = {16'd0, w_crc_rd};
            default:            w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_rdata <= '0;
        else if (avs_read) r_rdata <= w_rd_data;
    end

    assign avs_readdata = r_rdata;
    assign frame_irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
//==============================================================================
// Module : tb_vga_rx_monitor
// Directed self-checking bench for vga_rx_monitor using a scaled 4x2 raster.
// Rev    : 1.0  initial release
//==============================================================================
module tb_vga_rx_monitor;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int LP  = 10;
    localparam int HSF = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vga_hs, vga_vs, vga_blank;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        frame_irq;

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          irq_cnt = 0;
    logic        rd_d    = 1'b0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] crc_exp;

    vga_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_blank     (vga_blank),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .frame_irq     (frame_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", t, obs, exp);
        end
    endtask

    // Read results appear one cycle after the request; pop the matching expectation.
    always @(posedge clk) rd_d <= avs_read;
    always @(negedge clk) begin
        if (rd_d && exp_q.size() != 0) check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
    end

    always @(negedge clk) if (frame_irq === 1'b1) irq_cnt++;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            if (x[15] ^ d[i]) x = {x[14:0], 1'b0} ^ 16'h1021;
            else              x = {x[14:0], 1'b0};
        end
        return x;
    endfunction

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    // vs_mode: 0 high, 1 falls together with hs, 2 low for the whole line.
    task automatic drive_line(input int w, input int vs_mode, input bit wr_at_latch);
        for (int c = 0; c < LP; c++) begin
            @(negedge clk);
            vga_blank = (c < w);
            vga_hs    = !(c == HSF || c == HSF + 1);
            vga_vs    = (vs_mode == 0) ? 1'b1 : (vs_mode == 1) ? (c < HSF) : 1'b0;
            avs_write = wr_at_latch && (c == HSF + 1);
            if (wr_at_latch) begin
                avs_address   = 3'd0;
                avs_writedata = 32'h4;
            end
        end
    endtask

    task automatic drive_frame(input int w, input int nact, input bit wr_at_latch);
        for (int l = 0; l < nact; l++)
            drive_line(w, (l == nact - 1) ? 1 : 0, wr_at_latch && (l == nact - 1));
        drive_line(0, 2, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        vga_hs = 1'b1; vga_vs = 1'b1; vga_blank = 1'b0;
        vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
        avs_address = 3'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'h0;
`ifdef VGA_RX_CRC_EN
        crc_exp = 16'hFFFF;
        for (int p = 0; p < H * V * 3; p++) crc_exp = crc_byte(crc_exp, 8'h00);
`else
        crc_exp = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        check("rst_irq", {31'd0, frame_irq}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        rd(3'd0, 32'h0, "rst_status");
        rd(3'd5, 32'h0, "rst_crc");

        // First vs after reset only arms the monitor.
        drive_frame(H, V, 1'b0);
        rd(3'd4, 32'd0, "first_vs_fc");
        rd(3'd0, 32'h08, "first_vs_status");
        check("first_vs_irq", irq_cnt, 0);

        drive_frame(H, V, 1'b0);
        rd(3'd1, H,      "good_line_pixels");
        rd(3'd2, V,      "good_frame_lines");
        rd(3'd3, LP,     "good_hs_period");
        rd(3'd0, 32'h0D, "good_status");
        rd(3'd5, {16'd0, crc_exp}, "good_crc");
        rd(3'd6, 32'h0,  "addr6");
        rd(3'd7, 32'h0,  "addr7");
        rd(3'd4, 32'd1,  "good_fc");
        check("good_irq", irq_cnt, 1);
        avs_address = 3'd2;
        repeat (3) @(negedge clk);
        check("rd_hold", avs_readdata, 32'd1);

        drive_frame(H - 1, V, 1'b0);
        rd(3'd1, H - 1,  "bad_line_pixels");
        rd(3'd0, 32'h0E, "bad_status");
        rd(3'd4, 32'd2,  "bad_fc");
        drive_frame(H, V, 1'b0);
        rd(3'd0, 32'h0F, "recover_status");
        wr(3'd0, 32'h2);
        rd(3'd0, 32'h0D, "err_clr_status");
        wr(3'd1, 32'hFFFF);
        rd(3'd1, H,      "ignored_write");
        wr(3'd0, 32'h4);
        rd(3'd0, 32'h09, "done_clr_status");

        drive_frame(H, V, 1'b1);
        rd(3'd0, 32'h0D, "set_wins_status");
        rd(3'd4, 32'd4,  "set_wins_fc");

        // One line with blank held active far past 16-bit range.
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            vga_blank = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1;
        end
        drive_line(0, 1, 1'b0);
        drive_line(0, 2, 1'b0);
        rd(3'd1, 32'hFFFF, "sat_line_pixels");
        rd(3'd3, 32'hFFFF, "sat_hs_period");
        rd(3'd2, 32'd1,    "sat_frame_lines");
        rd(3'd0, 32'h0E,   "sat_status");
        rd(3'd4, 32'd5,    "sat_fc");
        check("sat_irq", irq_cnt, 5);

        // Reset in the middle of a frame.
        drive_line(H, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            vga_blank = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1;
        end
        @(negedge clk);
        reset_n   = 1'b0;
        vga_blank = 1'b0;
        @(negedge clk);
        check("mid_rst_irq", {31'd0, frame_irq}, 32'd0);
        rd(3'd0, 32'h0, "mid_rst_rd");
        reset_n = 1'b1;
        rd(3'd0, 32'h0, "post_rst_status");
        rd(3'd1, 32'h0, "post_rst_line_pixels");
        rd(3'd2, 32'h0, "post_rst_frame_lines");
        rd(3'd3, 32'h0, "post_rst_hs_period");
        rd(3'd4, 32'h0, "post_rst_fc");
        drive_line(H, 0, 1'b0);
        drive_line(H, 1, 1'b0);
        drive_line(0, 2, 1'b0);
        rd(3'd4, 32'd0,  "rearm_fc");
        rd(3'd0, 32'h08, "rearm_status");
        check("rearm_irq", irq_cnt, 5);
        drive_frame(H, V, 1'b0);
        rd(3'd1, H,      "resume_line_pixels");
        rd(3'd2, V,      "resume_frame_lines");
        rd(3'd3, LP,     "resume_hs_period");
        rd(3'd0, 32'h0D, "resume_status");
        rd(3'd4, 32'd1,  "resume_fc");
        check("resume_irq", irq_cnt, 6);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
